mdu: RTL and testbench

- Multiply/divide unit in the E stage of the pipelined MIPS core; owns architectural HI and LO.
- It is the responder side of the pipeline's stall protocol. The hazard unit issues an operation with start/op, and holds any later mult/div/mfhi/mflo/mthi/mtlo in D while this block reports busy.
- Results are committed to HI/LO only after a fixed latency, modelling the multi-cycle unit.

---
 rtl/mdu.sv | 126 ++++++++++++
 tb/tb_mdu.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Multiply/divide unit owning architectural HI/LO; results commit after a fixed busy latency.
// Optional MDU_BUSY_COMB_EN: busy also asserts combinationally in the issue cycle.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

  state_e      state, next_state;
  logic [3:0]  count;
  logic [31:0] pend_hi, pend_lo;
  logic        pend_wr;

  logic        is_mul, is_div, is_md, accept;
  logic [63:0] mul_a, mul_b, prod;
  logic        div_signed;
  logic [31:0] num, den_raw, den, quo, rem, div_lo, div_hi;

  assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div = (op == OP_DIV)  || (op == OP_DIVU);
  assign is_md  = is_mul || is_div;
  assign accept = (state == S_IDLE) && start;

  // One 64-bit multiplier; signedness comes from how the operands are extended.
  always_comb begin
    mul_a = {32'b0, A};
    mul_b = {32'b0, B};
    if (op == OP_MULT) begin
      mul_a = {{32{A[31]}}, A};
      mul_b = {{32{B[31]}}, B};
    end
    prod = mul_a * mul_b;
  end

  // Signed divide runs on magnitudes; quotient/remainder signs are restored afterwards.
  always_comb begin
    div_signed = (op == OP_DIV);
    num     = (div_signed && A[31]) ? (32'd0 - A) : A;
    den_raw = (div_signed && B[31]) ? (32'd0 - B) : B;
    den     = (den_raw == '0) ? 32'd1 : den_raw;
    quo     = num / den;
    rem     = num % den;
    div_lo  = (div_signed && (A[31] ^ B[31])) ? (32'd0 - quo) : quo;
    div_hi  = (div_signed && A[31]) ? (32'd0 - rem) : rem;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (accept && is_md) next_state = S_BUSY;
      S_BUSY: if (count == 4'd1) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      count   <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        case (op)
          OP_MULT, OP_MULTU: begin
            pend_hi <= prod[63:32];
            pend_lo <= prod[31:0];
            pend_wr <= 1'b1;
            count   <= 4'(MULT_CYCLES);
          end
          OP_DIV, OP_DIVU: begin
            pend_hi <= div_hi;
            pend_lo <= div_lo;
            pend_wr <= (B != '0);
            count   <= 4'(DIV_CYCLES);
          end
          OP_MTHI: HI <= A;
          OP_MTLO: LO <= A;
          default: ;
        endcase
      end else if (state == S_BUSY) begin
        count <= count - 4'd1;
        if (count == 4'd1 && pend_wr) begin
          HI <= pend_hi;
          LO <= pend_lo;
        end
      end
    end
  end

`ifdef MDU_BUSY_COMB_EN
  assign busy = (state == S_BUSY) | (start & is_md);
`else
  assign busy = (state == S_BUSY);
`endif

endmodule

// File: tb/tb_mdu.sv
// Randomized + directed bench for mdu; a cycle-level arithmetic model predicts busy/HI/LO.
module tb_mdu;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  // Model: remaining busy cycles plus pending result, from arithmetic definitions.
  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit          p_wr = 1'b0;
  bit          armed = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model_p
    longint          sa, sb;
    longint unsigned ua, ub, pr;
    if (reset) begin
      m_left = 0; m_hi = '0; m_lo = '0; p_wr = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && p_wr) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (start) begin
      case (op)
        3'd1: begin
          sa = longint'($signed(A)); sb = longint'($signed(B));
          pr = longint'(sa * sb);
          p_hi = pr[63:32]; p_lo = pr[31:0]; p_wr = 1'b1; m_left = MC;
        end
        3'd2: begin
          ua = {32'b0, A}; ub = {32'b0, B}; pr = ua * ub;
          p_hi = pr[63:32]; p_lo = pr[31:0]; p_wr = 1'b1; m_left = MC;
        end
        3'd3: begin
          p_wr = (B != 0);
          if (B != 0) begin
            sa = longint'($signed(A)); sb = longint'($signed(B));
            p_lo = 32'(sa / sb); p_hi = 32'(sa % sb);
          end
          m_left = DC;
        end
        3'd4: begin
          p_wr = (B != 0);
          if (B != 0) begin p_lo = A / B; p_hi = A % B; end
          m_left = DC;
        end
        3'd5: m_hi = A;
        3'd6: m_lo = A;
        default: ;
      endcase
    end
  end

  always @(posedge clk) begin : compare_p
    bit exp_busy;
    #1;
    if (armed) begin
      exp_busy = (m_left > 0);
`ifdef MDU_BUSY_COMB_EN
      exp_busy = exp_busy | (start && op >= 3'd1 && op <= 3'd4);
`endif
      check("cyc_busy", {31'b0, busy}, {31'b0, exp_busy});
      check("cyc_HI", HI, m_hi);
      check("cyc_LO", LO, m_lo);
    end
  end

  // Called at a negedge; drives one start pulse across the next rising edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    @(negedge clk); @(negedge clk);
    armed = 1'b1;
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_HI", HI, 32'h0);
    check("rst_LO", LO, 32'h0);
    reset = 1'b0;

    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    check("mult_len", 32'(n), 32'd5);
    check("mult_HI", HI, 32'hFFFF_FFFF);
    check("mult_LO", LO, 32'hFFFF_FFFA);

    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n);
    check("multu_len", 32'(n), 32'd5);
    check("multu_HI", HI, 32'hFFFF_FFFE);
    check("multu_LO", LO, 32'h0000_0001);

    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check("div_len", 32'(n), 32'd10);
    check("div_LO", LO, 32'hFFFF_FFFD);
    check("div_HI", HI, 32'hFFFF_FFFF);

    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check("divovf_LO", LO, 32'h8000_0000);
    check("divovf_HI", HI, 32'h0);

    issue(3'd5, 32'h1234, 32'h0);
    check("mthi_HI", HI, 32'h1234);
    check("mthi_busy", {31'b0, busy}, 32'h0);
    issue(3'd6, 32'h5678, 32'h0);
    check("mtlo_LO", LO, 32'h5678);
    check("mtlo_HI", HI, 32'h1234);
    check("mtlo_busy", {31'b0, busy}, 32'h0);

    issue(3'd5, 32'h11, 32'h0);
    issue(3'd6, 32'h22, 32'h0);
    issue(3'd4, 32'd7, 32'd0);
    wait_idle(n);
    check("div0_len", 32'(n), 32'd10);
    check("div0_HI", HI, 32'h11);
    check("div0_LO", LO, 32'h22);

    issue(3'd3, 32'd100, 32'd7);
    @(negedge clk); @(negedge clk);
    $display("note: deliberate start while busy (protocol violation) at %0t", $time);
    start = 1'b1; op = 3'd1; A = 32'd9; B = 32'd9;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    wait_idle(n);
    check("ignored_len", 32'(n), 32'd7);
    check("ignored_LO", LO, 32'd14);
    check("ignored_HI", HI, 32'd2);
    issue(3'd1, 32'd6, 32'd7);
    wait_idle(n);
    check("b2b_len", 32'(n), 32'd5);
    check("b2b_LO", LO, 32'd42);
    check("b2b_HI", HI, 32'd0);

    issue(3'd1, 32'h1234, 32'h5678);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_busy", {31'b0, busy}, 32'h0);
    check("rstmid_HI", HI, 32'h0);
    check("rstmid_LO", LO, 32'h0);
    repeat (8) @(negedge clk);
    check("rstmid_HI_late", HI, 32'h0);
    check("rstmid_LO_late", LO, 32'h0);

    repeat (600) begin
      reset = ($urandom_range(0, 149) == 0);
      if (m_left == 0 && !reset && $urandom_range(0, 1) == 1) begin
        start = 1'b1; op = 3'($urandom_range(0, 7)); A = pick(); B = pick();
      end else begin
        start = 1'b0; op = 3'($urandom_range(0, 7));
      end
      @(negedge clk);
    end
    reset = 1'b0; start = 1'b0; op = 3'd0;
    wait_idle(n);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
